decode_queue: RTL and testbench

- Registered, parametrised successor to the combinational instruction control decoder.
- Accepts fetched instructions over a valid/ready handshake and decodes each one to the team's 16-bit control word.
- Inserts load-use bubbles and buffers decoded entries in a FIFO_DEPTH-entry queue ahead of execute.
- Sits between fetch and execute. Supports pipeline flush from branch/jump resolution.

---
 rtl/decode_queue.sv | 254 +++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Registered instruction decoder with load-use bubble insertion and a decoded-entry FIFO ahead of execute.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds illegal / illegal_seen, locks intake after an illegal op).
module decode_queue #(
   parameter int FIFO_DEPTH = 4,
   parameter int CTRL_W     = 16,
   parameter int PC_W       = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [31:0]                   in_instr,
   input  logic [PC_W-1:0]               in_pc,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CTRL_W-1:0]             out_ctrl,
   output logic [31:0]                   out_instr,
   output logic [PC_W-1:0]               out_pc,
   output logic                          out_bubble,
   output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic                          illegal,
   output logic                          illegal_seen
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
   // and in_ready may depend on in_valid (hazard detection looks at the presented instruction).

   logic [15:0]       r_ctrl_mem  [FIFO_DEPTH];
   logic [31:0]       r_instr_mem [FIFO_DEPTH];
   logic [PC_W-1:0]   r_pc_mem    [FIFO_DEPTH];
   logic              r_bub_mem   [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_trk_valid;
   logic [4:0]        r_trk_rd;

   logic [6:0]        w_opcode;
   logic [2:0]        w_f3;
   logic              w_b30;
   logic [4:0]        w_rd;
   logic [4:0]        w_rs1;
   logic [4:0]        w_rs2;
   logic [15:0]       w_code;
   logic              w_use_rs1;
   logic              w_use_rs2;
   logic              w_is_load;
   logic              w_full;
   logic              w_empty;
   logic              w_hazard;
   logic              w_lock;
   logic              w_push_real;
   logic              w_push_bub;
   logic              w_push;
   logic              w_pop;
   logic [15:0]       w_wr_code;
   logic [31:0]       w_wr_instr;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_b30    = in_instr[30];
   assign w_rd     = in_instr[11:7];
   assign w_rs1    = in_instr[19:15];
   assign w_rs2    = in_instr[24:20];

   // Anything undecodable yields 0080 and reads no registers.
   always_comb begin
      w_code    = 16'h0080;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_is_load = 1'b0;
      case (w_opcode)
         7'h33: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            case (w_f3)
               3'd0:    w_code = w_b30 ? 16'h1601 : 16'h1001;
               3'd1:    w_code = 16'h1081;
               3'd2:    w_code = 16'h1101;
               3'd3:    w_code = 16'h1181;
               3'd4:    w_code = 16'h1201;
               3'd5:    w_code = w_b30 ? 16'h1681 : 16'h1281;
               3'd6:    w_code = 16'h1301;
               default: w_code = 16'h1381;
            endcase
         end
         7'h13: begin
            w_use_rs1 = 1'b1;
            case (w_f3)
               3'd0:    w_code = 16'h1041;
               3'd1:    w_code = 16'h10C1;
               3'd2:    w_code = 16'h1141;
               3'd3:    w_code = 16'h11C1;
               3'd4:    w_code = 16'h1241;
               3'd5:    w_code = w_b30 ? 16'h16C1 : 16'h12C1;
               3'd6:    w_code = 16'h1341;
               default: w_code = 16'h13C1;
            endcase
         end
         7'h03: begin
            if (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd2) begin
               w_code    = 16'h0041;
               w_use_rs1 = 1'b1;
               w_is_load = 1'b1;
            end else if (w_f3 == 3'd4 || w_f3 == 3'd5) begin
               w_code    = 16'h0051;
               w_use_rs1 = 1'b1;
               w_is_load = 1'b1;
            end
         end
         7'h23: begin
            if (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd2) begin
               w_code    = 16'h0842;
               w_use_rs1 = 1'b1;
               w_use_rs2 = 1'b1;
            end
         end
         7'h63: begin
            case (w_f3)
               3'd0:    w_code = 16'h0064;
               3'd1:    w_code = 16'h4064;
               3'd4:    w_code = 16'h8064;
               3'd5:    w_code = 16'hC064;
               3'd6:    w_code = 16'h0074;
               3'd7:    w_code = 16'h4074;
               default: w_code = 16'h0080;
            endcase
            w_use_rs1 = (w_f3 != 3'd2) && (w_f3 != 3'd3);
            w_use_rs2 = (w_f3 != 3'd2) && (w_f3 != 3'd3);
         end
         7'h17: w_code = 16'h1067;
         7'h37: w_code = 16'h17E7;
         7'h6F: w_code = 16'h2069;
         7'h67: begin
            if (w_f3 == 3'd0) begin
               w_code    = 16'h2041;
               w_use_rs1 = 1'b1;
            end
         end
         default: w_code = 16'h0080;
      endcase
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic r_ill_mem [FIFO_DEPTH];
   logic r_lock;
   logic r_ill_seen;
   logic w_illegal;

   assign w_illegal = (w_code == 16'h0080);
   assign w_lock    = r_lock;
`else
   assign w_lock    = 1'b0;
`endif

   assign w_full   = (r_count == FULL_CNT);
   assign w_empty  = (r_count == '0);
   assign w_hazard = in_valid && r_trk_valid &&
                     ((w_use_rs1 && (w_rs1 == r_trk_rd)) || (w_use_rs2 && (w_rs2 == r_trk_rd)));

   assign in_ready    = !w_full && !w_hazard && !flush && !w_lock;
   assign w_push_real = in_valid && in_ready;
   // A hazard with room left inserts a bubble; the stalled instruction enters next cycle.
   assign w_push_bub  = w_hazard && !w_full && !flush && !w_lock;
   assign w_push      = w_push_real || w_push_bub;
   assign w_pop       = !w_empty && out_ready;

   assign w_wr_code   = w_push_bub ? 16'h0080 : w_code;
   assign w_wr_instr  = w_push_bub ? 32'h0000_0013 : in_instr;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_ctrl_mem[r_wr_ptr]  <= w_wr_code;
         r_instr_mem[r_wr_ptr] <= w_wr_instr;
         r_pc_mem[r_wr_ptr]    <= in_pc;
         r_bub_mem[r_wr_ptr]   <= w_push_bub;
`ifdef DECODE_ILLEGAL_TRAP_EN
         r_ill_mem[r_wr_ptr]   <= w_push_real && w_illegal;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_trk_valid <= 1'b0;
         r_trk_rd    <= '0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_trk_valid <= 1'b0;
         r_trk_rd    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_push_real) begin
            r_trk_valid <= w_is_load && (w_rd != 5'd0);
            r_trk_rd    <= w_rd;
         end else if (w_push_bub) begin
            r_trk_valid <= 1'b0;
         end
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   // The lock is released by flush; the sticky flag only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock     <= 1'b0;
         r_ill_seen <= 1'b0;
      end else if (flush) begin
         r_lock     <= 1'b0;
      end else if (w_push_real && w_illegal) begin
         r_lock     <= 1'b1;
         r_ill_seen <= 1'b1;
      end
   end

   assign illegal      = !w_empty && r_ill_mem[r_rd_ptr];
   assign illegal_seen = r_ill_seen;
`endif

   always_comb begin
      out_ctrl   = '0;
      out_instr  = '0;
      out_pc     = '0;
      out_bubble = 1'b0;
      if (!w_empty) begin
         out_ctrl[15:0] = r_ctrl_mem[r_rd_ptr];
         out_instr      = r_instr_mem[r_rd_ptr];
         out_pc         = r_pc_mem[r_rd_ptr];
         out_bubble     = r_bub_mem[r_rd_ptr];
      end
   end

   assign out_valid = !w_empty;
   assign count     = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed steps from the test plan, then randomized traffic against a
// table-driven decode reference and a queue model of the decoded-entry FIFO.
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int PW    = 32;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [31:0]               in_instr;
   logic [PW-1:0]             in_pc;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [CW-1:0]             out_ctrl;
   logic [31:0]               out_instr;
   logic [PW-1:0]             out_pc;
   logic                      out_bubble;
   logic [$clog2(DEPTH):0]    count;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic                      illegal;
   logic                      illegal_seen;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   string cur_tag = "init";

   typedef struct packed {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f3c;
      logic        b30;
      logic        b30c;
      logic [15:0] ctrl;
      logic        u1;
      logic        u2;
      logic        ld;
   } op_t;

   typedef struct packed {
      logic [15:0] ctrl;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        bub;
      logic        ill;
   } ent_t;

   op_t  tbl[$];
   ent_t exp_q[$];
   bit   m_trk_v;
   logic [4:0] m_trk_rd;
   bit   m_lock;
   bit   m_seen;

   always #5 clk = ~clk;

   decode_queue #(.FIFO_DEPTH(DEPTH), .CTRL_W(CW), .PC_W(PW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_instr(out_instr), .out_pc(out_pc), .out_bubble(out_bubble),
      .count(count)
`ifdef DECODE_ILLEGAL_TRAP_EN
      , .illegal(illegal), .illegal_seen(illegal_seen)
`endif
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic op_t mk(input logic [6:0] o, input logic [2:0] f, input bit fc, input bit b,
                              input bit bc, input logic [15:0] c, input bit u1, input bit u2, input bit ld);
      op_t e;
      e.opc = o; e.f3 = f; e.f3c = fc; e.b30 = b; e.b30c = bc;
      e.ctrl = c; e.u1 = u1; e.u2 = u2; e.ld = ld;
      return e;
   endfunction

   task automatic build_table();
      tbl.push_back(mk(7'h33, 3'd0, 1, 0, 1, 16'h1001, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd0, 1, 1, 1, 16'h1601, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd1, 1, 0, 0, 16'h1081, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd2, 1, 0, 0, 16'h1101, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd3, 1, 0, 0, 16'h1181, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd4, 1, 0, 0, 16'h1201, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd5, 1, 0, 1, 16'h1281, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd5, 1, 1, 1, 16'h1681, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd6, 1, 0, 0, 16'h1301, 1, 1, 0));
      tbl.push_back(mk(7'h33, 3'd7, 1, 0, 0, 16'h1381, 1, 1, 0));
      tbl.push_back(mk(7'h13, 3'd0, 1, 0, 0, 16'h1041, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd1, 1, 0, 0, 16'h10C1, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd2, 1, 0, 0, 16'h1141, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd3, 1, 0, 0, 16'h11C1, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd4, 1, 0, 0, 16'h1241, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd5, 1, 0, 1, 16'h12C1, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd5, 1, 1, 1, 16'h16C1, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd6, 1, 0, 0, 16'h1341, 1, 0, 0));
      tbl.push_back(mk(7'h13, 3'd7, 1, 0, 0, 16'h13C1, 1, 0, 0));
      tbl.push_back(mk(7'h03, 3'd0, 1, 0, 0, 16'h0041, 1, 0, 1));
      tbl.push_back(mk(7'h03, 3'd1, 1, 0, 0, 16'h0041, 1, 0, 1));
      tbl.push_back(mk(7'h03, 3'd2, 1, 0, 0, 16'h0041, 1, 0, 1));
      tbl.push_back(mk(7'h03, 3'd4, 1, 0, 0, 16'h0051, 1, 0, 1));
      tbl.push_back(mk(7'h03, 3'd5, 1, 0, 0, 16'h0051, 1, 0, 1));
      tbl.push_back(mk(7'h23, 3'd0, 1, 0, 0, 16'h0842, 1, 1, 0));
      tbl.push_back(mk(7'h23, 3'd1, 1, 0, 0, 16'h0842, 1, 1, 0));
      tbl.push_back(mk(7'h23, 3'd2, 1, 0, 0, 16'h0842, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd0, 1, 0, 0, 16'h0064, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd1, 1, 0, 0, 16'h4064, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd4, 1, 0, 0, 16'h8064, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd5, 1, 0, 0, 16'hC064, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd6, 1, 0, 0, 16'h0074, 1, 1, 0));
      tbl.push_back(mk(7'h63, 3'd7, 1, 0, 0, 16'h4074, 1, 1, 0));
      tbl.push_back(mk(7'h17, 3'd0, 0, 0, 0, 16'h1067, 0, 0, 0));
      tbl.push_back(mk(7'h37, 3'd0, 0, 0, 0, 16'h17E7, 0, 0, 0));
      tbl.push_back(mk(7'h6F, 3'd0, 0, 0, 0, 16'h2069, 0, 0, 0));
      tbl.push_back(mk(7'h67, 3'd0, 1, 0, 0, 16'h2041, 1, 0, 0));
   endtask

   task automatic ref_decode(input logic [31:0] ins, output logic [15:0] c, output bit u1,
                             output bit u2, output bit ld, output bit lg);
      c = 16'h0080; u1 = 0; u2 = 0; ld = 0; lg = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (!lg && ins[6:0] == tbl[i].opc && (!tbl[i].f3c || ins[14:12] == tbl[i].f3) &&
             (!tbl[i].b30c || ins[30] == tbl[i].b30)) begin
            c = tbl[i].ctrl; u1 = tbl[i].u1; u2 = tbl[i].u2; ld = tbl[i].ld; lg = 1;
         end
      end
   endtask

   function automatic logic [31:0] gen_instr();
      op_t e;
      logic [31:0] w;
      if ($urandom_range(0, 24) == 0) return $urandom;
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      w = $urandom;
      w[6:0]   = e.opc;
      if (e.f3c)  w[14:12] = e.f3;
      if (e.b30c) w[30]    = e.b30;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   task automatic check_outputs(input string t);
      ent_t h;
      h = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk($sformatf("%s.out_valid", t), out_valid, exp_q.size() != 0);
      chk($sformatf("%s.count", t), count, exp_q.size());
      chk($sformatf("%s.out_ctrl", t), out_ctrl, h.ctrl);
      chk($sformatf("%s.out_instr", t), out_instr, h.instr);
      chk($sformatf("%s.out_pc", t), out_pc, h.pc);
      chk($sformatf("%s.out_bubble", t), out_bubble, h.bub);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk($sformatf("%s.illegal", t), illegal, h.ill);
      chk($sformatf("%s.illegal_seen", t), illegal_seen, m_seen);
`endif
   endtask

   // One clock: drive inputs, compare in_ready, advance the model, then compare the head after the edge.
   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy,
                        input bit fl, output bit rdy);
      logic [15:0] c;
      bit u1, u2, ld, lg, full, haz, rdy_exp;
      ent_t e;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
      rdy = in_ready;
      ref_decode(ins, c, u1, u2, ld, lg);
      if (rst) begin
         exp_q.delete(); m_trk_v = 0; m_lock = 0; m_seen = 0;
      end else begin
         full = (exp_q.size() == DEPTH);
         haz  = v && m_trk_v && ((u1 && ins[19:15] == m_trk_rd) || (u2 && ins[24:20] == m_trk_rd));
         rdy_exp = !fl && !full && !haz && !m_lock;
         chk($sformatf("%s.in_ready", cur_tag), rdy, rdy_exp);
         if (fl) begin
            exp_q.delete(); m_trk_v = 0; m_lock = 0;
         end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (v && rdy_exp) begin
               e = '{ctrl: c, instr: ins, pc: pc, bub: 1'b0, ill: !lg};
               exp_q.push_back(e);
               m_trk_v = ld && (ins[11:7] != 5'd0);
               m_trk_rd = ins[11:7];
`ifdef DECODE_ILLEGAL_TRAP_EN
               if (!lg) begin m_lock = 1; m_seen = 1; end
`endif
            end else if (haz && !full && !m_lock) begin
               e = '{ctrl: 16'h0080, instr: 32'h13, pc: pc, bub: 1'b1, ill: 1'b0};
               exp_q.push_back(e);
               m_trk_v = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      check_outputs(cur_tag);
      @(negedge clk);
   endtask

   task automatic drain();
      bit r;
      for (int k = 0; k < 2 * DEPTH && exp_q.size() != 0; k++) drive(0, 32'h0, 32'h0, 1, 0, r);
      chk($sformatf("%s.drained", cur_tag), count, 0);
   endtask

   initial begin
      bit r;
      bit v, ordy, fl;
      build_table();
      rst = 1; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 0;
      m_trk_v = 0; m_trk_rd = '0; m_lock = 0; m_seen = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;

      cur_tag = "reset";
      #1;
      chk("reset.in_ready", in_ready, 1);
      chk("reset.count", count, 0);
      check_outputs(cur_tag);
      @(negedge clk);

      cur_tag = "single_add";
      drive(1, 32'h003100B3, 32'h100, 0, 0, r);
      chk("single_add.valid_k", out_valid, 1);
      chk("single_add.ctrl_k", out_ctrl, 16'h1001);
      chk("single_add.pc_k", out_pc, 32'h100);
      chk("single_add.count_k", count, 1);
      drain();

      cur_tag = "load_use";
      drive(1, 32'h0000A283, 32'h104, 1, 0, r);
      chk("load_use.lw_ctrl_k", out_ctrl, 16'h0041);
      drive(1, 32'h00728333, 32'h108, 1, 0, r);
      chk("load_use.stall_rdy_k", r, 0);
      chk("load_use.bub_ctrl_k", out_ctrl, 16'h0080);
      chk("load_use.bub_flag_k", out_bubble, 1);
      chk("load_use.bub_instr_k", out_instr, 32'h13);
      drive(1, 32'h00728333, 32'h108, 1, 0, r);
      chk("load_use.accept_rdy_k", r, 1);
      chk("load_use.add_ctrl_k", out_ctrl, 16'h1001);
      chk("load_use.add_bub_k", out_bubble, 0);
      drain();

      cur_tag = "load_x0";
      drive(1, 32'h00002003, 32'h200, 1, 0, r);
      chk("load_x0.lw_ctrl_k", out_ctrl, 16'h0041);
      drive(1, 32'h00728333, 32'h204, 1, 0, r);
      chk("load_x0.rdy_k", r, 1);
      chk("load_x0.add_ctrl_k", out_ctrl, 16'h1001);
      drain();

      cur_tag = "fill";
      drive(1, 32'h40310033, 32'h300, 0, 0, r);
      drive(1, 32'h00100093, 32'h304, 0, 0, r);
      drive(1, 32'h00001137, 32'h308, 0, 0, r);
      drive(1, 32'h0000006F, 32'h30C, 0, 0, r);
      chk("fill.count4_k", count, 4);
      chk("fill.head_k", out_ctrl, 16'h1601);
      drive(1, 32'h00000063, 32'h310, 0, 0, r);
      chk("fill.full_rdy_k", r, 0);
      chk("fill.full_count_k", count, 4);
      drive(0, 32'h0, 32'h0, 1, 0, r);
      chk("fill.pop_count_k", count, 3);
      chk("fill.pop_head_k", out_ctrl, 16'h1041);
      drive(1, 32'h00000063, 32'h310, 1, 0, r);
      chk("fill.pushpop_count_k", count, 3);
      chk("fill.pushpop_head_k", out_ctrl, 16'h17E7);
      drive(1, 32'h003100B3, 32'h314, 0, 0, r);
      chk("fill.wrap_count_k", count, 4);
      drive(0, 32'h0, 32'h0, 1, 0, r);
      chk("fill.order1_k", out_ctrl, 16'h2069);
      drive(0, 32'h0, 32'h0, 1, 0, r);
      chk("fill.order2_k", out_ctrl, 16'h0064);
      drive(0, 32'h0, 32'h0, 1, 0, r);
      chk("fill.order3_k", out_ctrl, 16'h1001);
      chk("fill.order3_pc_k", out_pc, 32'h314);
      drain();

      cur_tag = "flush";
      drive(1, 32'h003100B3, 32'h500, 0, 0, r);
      drive(1, 32'h00100093, 32'h504, 0, 0, r);
      drive(1, 32'h0000A283, 32'h508, 0, 0, r);
      chk("flush.count3_k", count, 3);
      drive(1, 32'h00728333, 32'h50C, 0, 1, r);
      chk("flush.rdy_k", r, 0);
      chk("flush.count_k", count, 0);
      chk("flush.valid_k", out_valid, 0);
      drive(1, 32'h00728333, 32'h50C, 0, 0, r);
      chk("flush.nobubble_rdy_k", r, 1);
      chk("flush.nobubble_ctrl_k", out_ctrl, 16'h1001);
      drain();

      cur_tag = "illegal";
      drive(1, 32'hFFFFFFFF, 32'h400, 0, 0, r);
      chk("illegal.ctrl_k", out_ctrl, 16'h0080);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("illegal.flag_k", illegal, 1);
      chk("illegal.seen_k", illegal_seen, 1);
      drive(1, 32'h003100B3, 32'h404, 0, 0, r);
      chk("illegal.locked_rdy_k", r, 0);
      drive(0, 32'h0, 32'h0, 0, 1, r);
      drive(1, 32'h003100B3, 32'h404, 0, 0, r);
      chk("illegal.unlocked_rdy_k", r, 1);
      chk("illegal.seen_sticky_k", illegal_seen, 1);
`else
      drive(1, 32'h003100B3, 32'h404, 0, 0, r);
      chk("illegal.flows_rdy_k", r, 1);
      chk("illegal.flows_count_k", count, 2);
`endif
      drain();

      cur_tag = "mid_reset";
      drive(1, 32'h0000A283, 32'h600, 0, 0, r);
      drive(1, 32'h003100B3, 32'h604, 0, 0, r);
      rst = 1;
      drive(1, 32'h00728333, 32'h608, 1, 1, r);
      rst = 0;
      chk("mid_reset.count_k", count, 0);
      drive(1, 32'h00728333, 32'h608, 0, 0, r);
      chk("mid_reset.nobubble_rdy_k", r, 1);
      drain();

      cur_tag = "random";
      for (int i = 0; i < 800; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 29) == 0);
         drive(v, gen_instr(), $urandom, ordy, fl, r);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
